// File: rtl/varredura_display.sv
// Scan controller for the two-digit seven-segment display: alternates the
// actions and speed digits with an optional dark gap between them.
module varredura_display #(
    parameter int DIV         = 50000,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1,
    parameter int CW          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       aux,
    output logic [1:0] dig_n,
    output logic       blank,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIG0   = 3'd1,
        BLANK0 = 3'd2,
        DIG1   = 3'd3,
        BLANK1 = 3'd4
    } state_t;

    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] ON_M1    = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] BLANK_M1 = CW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);
    localparam bit            NO_BLANK = (BLANK_TICKS == 0);

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] ph_cnt_q, ph_cnt_d;
    logic          aux_q, aux_d;
    logic [1:0]    dig_n_q, dig_n_d;
    logic          blank_q, blank_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic [CW-1:0] ph_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            ph_cnt_q     <= '0;
            aux_q        <= 1'b0;
            dig_n_q      <= 2'b11;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            ph_cnt_q     <= ph_cnt_d;
            aux_q        <= aux_d;
            dig_n_q      <= dig_n_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ph_cnt_d  = ph_cnt_q;
        tick      = (div_cnt_q == DIV_M1);
        ph_last   = ((state_q == DIG0) || (state_q == DIG1)) ? ON_M1 : BLANK_M1;
        if (!enable) begin
            state_d   = IDLE;
            div_cnt_d = '0;
            ph_cnt_d  = '0;
        end else if (state_q == IDLE) begin
            state_d   = DIG0;
            div_cnt_d = '0;
            ph_cnt_d  = '0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
            if (tick) begin
                if (ph_cnt_q == ph_last) begin
                    ph_cnt_d = '0;
                    case (state_q)
                        DIG0:    state_d = NO_BLANK ? DIG1 : BLANK0;
                        BLANK0:  state_d = DIG1;
                        DIG1:    state_d = NO_BLANK ? DIG0 : BLANK1;
                        BLANK1:  state_d = DIG0;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    ph_cnt_d = ph_cnt_q + CW'(1);
                end
            end
        end
    end

    // Outputs are decoded from the next state so they land in flops together
    // with the state they describe.
    always_comb begin
        aux_d        = 1'b0;
        dig_n_d      = 2'b11;
        blank_d      = 1'b1;
        frame_done_d = (state_d == DIG0) && ((state_q == DIG1) || (state_q == BLANK1));
        case (state_d)
            DIG0:    begin aux_d = 1'b0; dig_n_d = 2'b10; blank_d = 1'b0; end
            BLANK0:  begin aux_d = 1'b1; dig_n_d = 2'b11; blank_d = 1'b1; end
            DIG1:    begin aux_d = 1'b1; dig_n_d = 2'b01; blank_d = 1'b0; end
            default: begin aux_d = 1'b0; dig_n_d = 2'b11; blank_d = 1'b1; end
        endcase
    end

    assign aux        = aux_q;
    assign dig_n      = dig_n_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display: a time-since-enable model checked every cycle
// on two builds (with and without blank phase), plus directed literal checks.
module tb_varredura_display;

    localparam int DIV = 4;
    localparam int ON  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       aux0, aux1, fd0, fd1, blank0, blank1;
    logic [1:0] dig0, dig1;

    int n_cmp = 0;
    int n_bad = 0;
    int run   = -1;
    bit started = 1'b0;

    always #5 clk = ~clk;

    varredura_display #(.DIV(DIV), .ON_TICKS(ON), .BLANK_TICKS(1), .CW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .aux(aux0), .dig_n(dig0), .blank(blank0), .frame_done(fd0));

    varredura_display #(.DIV(DIV), .ON_TICKS(ON), .BLANK_TICKS(0), .CW(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .aux(aux1), .dig_n(dig1), .blank(blank1), .frame_done(fd1));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycles since the scan (re)started from DIG0; -1 means dark/idle.
    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n || !enable) run <= -1;
        else                   run <= run + 1;
    end

    // Expected {aux, dig_n, blank, frame_done} from elapsed time alone.
    function automatic logic [4:0] expect_out(input int t, input int bl);
        int per, p;
        if (t < 0) return {1'b0, 2'b11, 1'b1, 1'b0};
        per = 2 * DIV * (ON + bl);
        p   = t % per;
        if (p < DIV * ON)               return {1'b0, 2'b10, 1'b0, (t > 0 && p == 0)};
        else if (p < DIV * (ON + bl))   return {1'b1, 2'b11, 1'b1, 1'b0};
        else if (p < DIV * (2*ON + bl)) return {1'b1, 2'b01, 1'b0, 1'b0};
        else                            return {1'b0, 2'b11, 1'b1, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            logic [4:0] e0, e1;
            e0 = expect_out(run, 1);
            e1 = expect_out(run, 0);
            check("m0_aux",   aux0,   e0[4]);
            check("m0_dig_n", dig0,   e0[3:2]);
            check("m0_blank", blank0, e0[1]);
            check("m0_frame", fd0,    e0[0]);
            check("m1_aux",   aux1,   e1[4]);
            check("m1_dig_n", dig1,   e1[3:2]);
            check("m1_blank", blank1, e1[1]);
            check("m1_frame", fd1,    e1[0]);
            check("excl0", int'(dig0 != 2'b00), 1);
            check("excl1", int'(dig1 != 2'b00), 1);
            if (!blank0) check("onehot0", int'(dig0 == 2'b10 || dig0 == 2'b01), 1);
            if (!blank1) check("onehot1", int'(dig1 == 2'b10 || dig1 == 2'b01), 1);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_aux"},   aux0,   0);
        check({tag, "_dig_n"}, dig0,   3);
        check({tag, "_blank"}, blank0, 1);
        check({tag, "_frame"}, fd0,    0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        rst_n = 1'b1;

        // Full frame with hand-computed landmarks for both builds
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            case (k)
                0:  begin check("f_k0_dig", dig0, 2); check("f_k0_aux", aux0, 0); end
                11: check("f_k11_dig", dig0, 2);
                12: begin check("f_k12_aux", aux0, 1); check("f_k12_dig", dig0, 3);
                          check("nb_k12_dig", dig1, 1); check("nb_k12_blank", blank1, 0); end
                16: begin check("f_k16_dig", dig0, 1); check("f_k16_aux", aux0, 1); end
                23: check("nb_k23_dig", dig1, 1);
                24: begin check("nb_k24_frame", fd1, 1); check("nb_k24_dig", dig1, 2); end
                28: begin check("f_k28_aux", aux0, 0); check("f_k28_blank", blank0, 1); end
                31: check("f_k31_frame", fd0, 0);
                32: begin check("f_k32_frame", fd0, 1); check("f_k32_dig", dig0, 2); end
                33: check("f_k33_frame", fd0, 0);
                default: ;
            endcase
        end

        // Disable in the middle of DIG1, then restart
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        check("dis_pre_dig", dig0, 1);
        enable = 1'b0;
        @(negedge clk);
        check_reset_vals("dis");
        enable = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k < 12) begin
                check("reen_dig", dig0, 2);
                check("reen_frame", fd0, 0);
            end else begin
                check("reen_k12_aux", aux0, 1);
            end
        end

        // One-cycle reset pulse inside BLANK0
        @(negedge clk);
        check("rp_pre_blank", blank0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_pulse");
        rst_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 0)  check("rp_k0_dig", dig0, 2);
            if (k == 11) check("rp_k11_dig", dig0, 2);
            if (k == 12) begin check("rp_k12_blank", blank0, 1); check("rp_k12_aux", aux0, 1); end
        end

        // Random enable toggling with rare reset pulses
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            rst_n = ($urandom_range(0, 999) != 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
